// File: rtl/r5p_wbu_pkg.sv
// r5p_wbu_pkg: shared types, load encodings and helpers for the R5P write-back unit
package r5p_wbu_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        ALU  = 2'd1,
        LOAD = 2'd2
    } wb_sel_t;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } wbu_state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // Half needs an even address, word needs a word-aligned address, bytes are always fine.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] adr);
        return f3[1] ? (adr != 2'b00) : (f3[0] & adr[0]);
    endfunction

endpackage

// File: rtl/r5p_load_align.sv
// r5p_load_align: selects the addressed byte/half/word lane of a load word and sign/zero-extends it
module r5p_load_align #(
    parameter int XLEN = 32
) (
    input  logic [2:0]      f3_i,
    input  logic [1:0]      adr_i,
    input  logic [XLEN-1:0] rdt_i,
    output logic [XLEN-1:0] dat_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        sx;

    assign byte_lane = rdt_i[{adr_i, 3'b000} +: 8];
    assign half_lane = rdt_i[{adr_i[1], 4'b0000} +: 16];
    assign sx        = ~f3_i[2];
    assign dat_o     = f3_i[1] ? rdt_i
                     : f3_i[0] ? {{(XLEN-16){sx & half_lane[15]}}, half_lane}
                     : {{(XLEN-8){sx & byte_lane[7]}}, byte_lane};

endmodule

// File: rtl/r5p_wbu.sv
// r5p_wbu: write-back unit driving the GPR write port; R5P_WBU_MISALIGN_EN adds ld_mis and suppresses misaligned load writes
module r5p_wbu
    import r5p_wbu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exe_vld,
    output logic            exe_rdy,
    input  logic [1:0]      exe_sel,
    input  logic [AW-1:0]   exe_rd,
    input  logic [XLEN-1:0] exe_alu,
    input  logic [2:0]      exe_f3,
    input  logic [1:0]      exe_adr,
    input  logic            lsu_vld,
    input  logic [XLEN-1:0] lsu_rdt,
    output logic            e_rd,
    output logic [AW-1:0]   a_rd,
    output logic [XLEN-1:0] d_rd,
    output logic            ld_bsy,
    output logic [AW-1:0]   ld_rd
`ifdef R5P_WBU_MISALIGN_EN
    ,
    output logic            ld_mis
`endif
);

    wbu_state_t      state_q, state_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      adr_q, adr_d;
    logic            e_rd_q, e_rd_d;
    logic [AW-1:0]   a_rd_q, a_rd_d;
    logic [XLEN-1:0] d_rd_q, d_rd_d;
    logic [XLEN-1:0] ld_dat;
    logic            acc, rsp, drop, waiting;

    assign waiting = (state_q == LOAD_WAIT);
    assign exe_rdy = rst & ~waiting;
    assign acc     = exe_vld & exe_rdy;
    assign rsp     = waiting & lsu_vld;
    assign ld_bsy  = waiting & (rd_q != '0);
    assign ld_rd   = waiting ? rd_q : '0;
    assign e_rd    = e_rd_q;
    assign a_rd    = a_rd_q;
    assign d_rd    = d_rd_q;

    r5p_load_align #(.XLEN(XLEN)) u_align (
        .f3_i  (f3_q),
        .adr_i (adr_q),
        .rdt_i (lsu_rdt),
        .dat_o (ld_dat)
    );

`ifdef R5P_WBU_MISALIGN_EN
    logic mis_q, ld_mis_q;
    assign drop   = rsp & mis_q;
    assign ld_mis = ld_mis_q;
    // misalignment is judged at accept and reported when the response would have written
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mis_q    <= 1'b0;
            ld_mis_q <= 1'b0;
        end else begin
            mis_q    <= (acc && exe_sel == LOAD) ? misaligned(exe_f3, exe_adr) : mis_q;
            ld_mis_q <= drop;
        end
    end
`else
    assign drop = 1'b0;
`endif

    // next state, load capture and the single write per retired instruction
    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        f3_d    = f3_q;
        adr_d   = adr_q;
        e_rd_d  = 1'b0;
        a_rd_d  = a_rd_q;
        d_rd_d  = d_rd_q;
        if (acc && exe_sel == LOAD) begin
            state_d = LOAD_WAIT;
            rd_d    = exe_rd;
            f3_d    = exe_f3;
            adr_d   = exe_adr;
        end
        if (acc && exe_sel == ALU) begin
            e_rd_d = 1'b1;
            a_rd_d = exe_rd;
            d_rd_d = exe_alu;
        end
        if (rsp) begin
            state_d = IDLE;
            e_rd_d  = ~drop;
            a_rd_d  = drop ? a_rd_q : rd_q;
            d_rd_d  = drop ? d_rd_q : ld_dat;
        end
    end

    // state, pending-load context and registered write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rd_q    <= '0;
            f3_q    <= '0;
            adr_q   <= '0;
            e_rd_q  <= 1'b0;
            a_rd_q  <= '0;
            d_rd_q  <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            f3_q    <= f3_d;
            adr_q   <= adr_d;
            e_rd_q  <= e_rd_d;
            a_rd_q  <= a_rd_d;
            d_rd_q  <= d_rd_d;
        end
    end

endmodule
